// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath helpers.
//   calc_state_e : search controller states (IDLE, QUERY, DONE)
//   CALC_WIDTH   : default operand/result width
//   REPLY_*      : one-hot compare reply encodings, ordered {lt, eq, gt}
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    QUERY = 2'd1,
    DONE  = 2'd2
  } calc_state_e;

  localparam int CALC_WIDTH = 8;

  localparam logic [2:0] REPLY_LT = 3'b100;
  localparam logic [2:0] REPLY_EQ = 3'b010;
  localparam logic [2:0] REPLY_GT = 3'b001;

endpackage

// File: rtl/sar_search.sv
// Successive-approximation search engine (compare-interface initiator).
// Presents trial values to a magnitude-compare responder holding a hidden
// target and rebuilds that target MSB-first from the lt/eq/gt replies.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      begin a search (sampled only in IDLE)
//   busy                       search in progress
//   query_valid, query_data    trial value offered to the responder
//   resp_valid, resp_lt/eq/gt  responder reply (accepted while query_valid)
//   done                       one-cycle pulse at the end of a search
//   result, found, error       outcome, held until the next accepted start
//
// Build option: SAR_EARLY_EXIT_EN -- when defined, an eq reply finishes the
// search immediately with the current trial as the result. When undefined,
// eq is treated as lt and every bit is always queried.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last outcome
// QUERY | trial on query_data, waiting for a reply
// DONE  | one-cycle done pulse, then back to IDLE
module sar_search
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             query_valid,
  output logic [WIDTH-1:0] query_data,
  input  logic             resp_valid,
  input  logic             resp_lt,
  input  logic             resp_eq,
  input  logic             resp_gt,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             error
);

  localparam int BW = $clog2(WIDTH);

  calc_state_e      state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] qdata_q, qdata_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             found_q, found_d;
  logic             error_q, error_d;

  logic [2:0]       reply;
  logic             reply_onehot;
  logic [WIDTH-1:0] acc_keep;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      bit_q    <= '0;
      qdata_q  <= '0;
      result_q <= '0;
      found_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      bit_q    <= bit_d;
      qdata_q  <= qdata_d;
      result_q <= result_d;
      found_q  <= found_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    bit_d    = bit_q;
    qdata_d  = qdata_q;
    result_d = result_q;
    found_d  = found_q;
    error_d  = error_q;

    reply        = {resp_lt, resp_eq, resp_gt};
    reply_onehot = (reply == REPLY_LT) || (reply == REPLY_EQ) || (reply == REPLY_GT);
    // The trial is acc with the bit under test set, so keeping the bit
    // is simply adopting the trial.
    acc_keep     = (reply == REPLY_GT) ? acc_q : qdata_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = QUERY;
          acc_d   = '0;
          bit_d   = BW'(WIDTH - 1);
          qdata_d = WIDTH'(1) << (WIDTH - 1);
          found_d = 1'b0;
          error_d = 1'b0;
        end
      end

      QUERY: begin
        if (resp_valid) begin
          if (!reply_onehot) begin
            error_d  = 1'b1;
            found_d  = 1'b0;
            result_d = acc_q;
            qdata_d  = '0;
            state_d  = DONE;
          end else begin
`ifdef SAR_EARLY_EXIT_EN
            if (reply == REPLY_EQ) begin
              acc_d    = qdata_q;
              result_d = qdata_q;
              found_d  = 1'b1;
              qdata_d  = '0;
              state_d  = DONE;
            end else
`endif
            if (bit_q == '0) begin
              acc_d    = acc_keep;
              result_d = acc_keep;
              found_d  = 1'b1;
              qdata_d  = '0;
              state_d  = DONE;
            end else begin
              acc_d   = acc_keep;
              bit_d   = bit_q - BW'(1);
              qdata_d = acc_keep | (WIDTH'(1) << (bit_q - BW'(1)));
            end
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy        = (state_q == QUERY);
  assign query_valid = (state_q == QUERY);
  assign query_data  = qdata_q;
  assign done        = (state_q == DONE);
  assign result      = result_q;
  assign found       = found_q;
  assign error       = error_q;

endmodule

// File: tb/tb_sar_search.sv
module tb_sar_search;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy;
  logic       query_valid;
  logic [7:0] query_data;
  logic       resp_valid = 1'b0;
  logic       resp_lt = 1'b0;
  logic       resp_eq = 1'b0;
  logic       resp_gt = 1'b0;
  logic       done;
  logic [7:0] result;
  logic       found;
  logic       error;

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0] queries [16];
  int nq;
  int done_cyc;
  bit stable_ok;
  bit busy_ok;
  bit aborted;

  sar_search #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .query_valid(query_valid), .query_data(query_data),
    .resp_valid(resp_valid), .resp_lt(resp_lt), .resp_eq(resp_eq), .resp_gt(resp_gt),
    .done(done), .result(result), .found(found), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycle 0 is the cycle in which start is sampled. The responder compares
  // against tgt and replies after dly wait cycles; bad_q corrupts that query's
  // reply (lt and gt both set); abort_q pulls rst_n low on that query.
  task automatic run_search(input logic [7:0] tgt, input int dly, input int bad_q, input int abort_q);
    int wait_cnt;
    logic [7:0] held;
    nq = 0; done_cyc = -1; stable_ok = 1; busy_ok = 1; aborted = 0;
    wait_cnt = 0; held = '0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc < 200; cyc++) begin
      resp_valid = 1'b0; resp_lt = 1'b0; resp_eq = 1'b0; resp_gt = 1'b0;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (!busy) busy_ok = 0;
      if (query_valid) begin
        if (wait_cnt == 0) held = query_data;
        else if (query_data !== held) stable_ok = 0;
        if (wait_cnt == dly) begin
          if (nq < 16) queries[nq] = query_data;
          nq++;
          wait_cnt = 0;
          if (abort_q == nq) begin
            rst_n = 1'b0;
            aborted = 1;
            break;
          end
          resp_valid = 1'b1;
          resp_lt = (query_data < tgt);
          resp_eq = (query_data == tgt);
          resp_gt = (query_data > tgt);
          if (bad_q == nq) begin
            resp_lt = 1'b1; resp_eq = 1'b0; resp_gt = 1'b1;
          end
        end else begin
          wait_cnt++;
        end
      end
      @(posedge clk); #1;
    end
    resp_valid = 1'b0; resp_lt = 1'b0; resp_eq = 1'b0; resp_gt = 1'b0;
    if (!aborted) check("done_seen", 32'(done_cyc != -1), 32'd1);
  endtask

  initial begin
    logic [7:0] exp_q [8];

    // Reset state
    #1;
    check("rst_busy", busy, 0);
    check("rst_qvalid", query_valid, 0);
    check("rst_qdata", query_data, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_found", found, 0);
    check("rst_error", error, 0);
    #20 rst_n = 1'b1;

    // Target 0xA5, zero-wait responder
    exp_q = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    run_search(8'hA5, 0, 0, 0);
    check("a5_nq", nq, 8);
    for (int i = 0; i < 8; i++) check($sformatf("a5_q%0d", i), queries[i], exp_q[i]);
    check("a5_done_cyc", done_cyc, 9);
    check("a5_result", result, 8'hA5);
    check("a5_found", found, 1);
    check("a5_error", error, 0);
    check("a5_busy_in_done", busy, 0);
    check("a5_qvalid_in_done", query_valid, 0);
    check("a5_busy_during", busy_ok, 1);
    @(posedge clk); #1;
    check("a5_done_one_cycle", done, 0);

    // Replies while idle are ignored
    resp_valid = 1'b1; resp_lt = 1'b1; resp_eq = 1'b1; resp_gt = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    resp_valid = 1'b0; resp_lt = 1'b0; resp_eq = 1'b0; resp_gt = 1'b0;
    check("idle_resp_error", error, 0);
    check("idle_resp_result", result, 8'hA5);
    check("idle_resp_busy", busy, 0);

    // Target 0x00: walking-one queries, all gt
    run_search(8'h00, 0, 0, 0);
    check("z_nq", nq, 8);
    for (int i = 0; i < 8; i++) check($sformatf("z_q%0d", i), queries[i], 8'h80 >> i);
    check("z_result", result, 8'h00);
    check("z_found", found, 1);

    // Target 0x80: eq on the very first trial
    run_search(8'h80, 0, 0, 0);
`ifdef SAR_EARLY_EXIT_EN
    check("m_nq", nq, 1);
    check("m_done_cyc", done_cyc, 2);
`else
    check("m_nq", nq, 8);
    check("m_done_cyc", done_cyc, 9);
    check("m_q1", queries[1], 8'hC0);
    check("m_q7", queries[7], 8'h81);
`endif
    check("m_result", result, 8'h80);
    check("m_found", found, 1);

    // Target 0x3C, responder with 3-cycle reply delay
    run_search(8'h3C, 3, 0, 0);
`ifdef SAR_EARLY_EXIT_EN
    check("d_nq", nq, 6);
    check("d_done_cyc", done_cyc, 1 + 6 * 4);
`else
    check("d_nq", nq, 8);
    check("d_done_cyc", done_cyc, 1 + 8 * 4);
`endif
    check("d_stable", stable_ok, 1);
    check("d_result", result, 8'h3C);
    check("d_found", found, 1);

    // Corrupt reply on 3rd query, target 0xA5 (acc is 0x80 at that point)
    run_search(8'hA5, 0, 3, 0);
    check("e_nq", nq, 3);
    check("e_done_cyc", done_cyc, 4);
    check("e_error", error, 1);
    check("e_found", found, 0);
    check("e_result", result, 8'h80);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("e_cleared_by_start", error, 0);
    check("e_busy_after_start", busy, 1);
    // Finish this search with a clean responder so the engine returns to idle
    begin
      int guard;
      guard = 0;
      while (!done && guard < 100) begin
        resp_valid = query_valid;
        resp_lt = (query_data < 8'h11);
        resp_eq = (query_data == 8'h11);
        resp_gt = (query_data > 8'h11);
        @(posedge clk); #1;
        guard++;
      end
      resp_valid = 1'b0; resp_lt = 1'b0; resp_eq = 1'b0; resp_gt = 1'b0;
      check("e_recover_result", result, 8'h11);
    end

    // Reset during the 5th query
    run_search(8'hA5, 0, 0, 5);
    check("r_aborted", aborted, 1);
    #1;
    check("r_busy", busy, 0);
    check("r_qvalid", query_valid, 0);
    check("r_qdata", query_data, 0);
    check("r_done", done, 0);
    check("r_result", result, 0);
    check("r_found", found, 0);
    check("r_error", error, 0);
    begin
      bit saw_done;
      saw_done = 0;
      repeat (3) begin
        @(posedge clk); #1;
        if (done) saw_done = 1;
      end
      rst_n = 1'b1;
      repeat (2) begin
        @(posedge clk); #1;
        if (done) saw_done = 1;
      end
      check("r_no_done", saw_done, 0);
    end
    run_search(8'h3C, 0, 0, 0);
    check("r_new_result", result, 8'h3C);
    check("r_new_found", found, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
